// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the 8N1 UART byte receiver.
// State encodings, oversampling constants and the bit voter.
package uart_byte_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int          OVERSAMPLE   = 16;
  localparam int          DEF_CLK_FREQ = 50_000_000;
  localparam logic [3:0]  SAMPLE_LO    = 4'd6;
  localparam logic [3:0]  SAMPLE_HI    = 4'd8;
  localparam logic [3:0]  SUB_LAST     = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]  BIT_LAST     = 3'd7;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_byte_rx_baud_tick.sv
// Oversampling divider: one tick every BPS_DR+1 clocks while run is high.
// Dropping run clears the divider so the next run starts phase-aligned.
module uart_baud_tick #(
  parameter int BPS_DR = 26
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(BPS_DR);

  logic [15:0] div_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= 16'd0;
    end else if (!run || div_cnt == TERM) begin
      div_cnt <= 16'd0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  assign tick = run && (div_cnt == TERM);

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-FF sync, 16x oversampling, 3-sample majority vote.
// Delivers one byte with a 1-cycle rx_done, or a 1-cycle frame_err.
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int baud     = 115200,
  parameter int BPS_DR   = CLK_FREQ / (baud * OVERSAMPLE) - 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err
);

  logic       rx_meta;
  logic       rx_s;
  rx_state_t  state;
  logic [3:0] sub_cnt;
  logic [3:0] idle_cnt;
  logic [2:0] bit_idx;
  logic [2:0] samp;
  logic [7:0] shreg;
  logic       run;
  logic       tick;
  logic       in_frame;
  logic       in_win;
  logic       mid;
  logic       last;
  logic       vote;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Divider free-runs in WAIT_IDLE; held cleared in IDLE
  assign run = (state != IDLE);

  uart_baud_tick #(
    .BPS_DR (BPS_DR)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .tick    (tick)
  );

  assign in_frame = (state == START) || (state == DATA) || (state == STOP);
  assign in_win   = tick && (sub_cnt >= SAMPLE_LO) && (sub_cnt <= SAMPLE_HI);
  assign mid      = tick && (sub_cnt == SAMPLE_HI);
  assign last     = tick && (sub_cnt == SUB_LAST);
  // The third vote sample is the live rx_s on the SAMPLE_HI tick
  assign vote     = maj3({samp[1:0], rx_s});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_IDLE;
      sub_cnt   <= 4'd0;
      idle_cnt  <= 4'd0;
      bit_idx   <= 3'd0;
      samp      <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      if (in_frame && tick) begin
        sub_cnt <= sub_cnt + 4'd1;
      end
      if (in_frame && in_win) begin
        samp <= {samp[1:0], rx_s};
      end
      unique case (state)
        WAIT_IDLE: begin
          if (!rx_s) begin
            idle_cnt <= 4'd0;
          end else if (tick) begin
            if (idle_cnt == SUB_LAST) begin
              idle_cnt <= 4'd0;
              state    <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + 4'd1;
            end
          end
        end
        IDLE: begin
          sub_cnt <= 4'd0;
          if (!rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (mid && vote) begin
            state <= IDLE;
          end else if (last) begin
            state   <= DATA;
            bit_idx <= 3'd0;
          end
        end
        DATA: begin
          if (mid) begin
            shreg <= {vote, shreg[7:1]};
          end
          if (last) begin
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed
          if (mid) begin
            if (vote) begin
              data    <= shreg;
              rx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end
        end
        default: begin
          state <= WAIT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at a scaled-down rate (4 clk per sub-tick).
// A line model drives frames; expected bytes go through a scoreboard queue.
module tb_uart_byte_rx;
  import uart_byte_rx_pkg::*;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 781_250;
  localparam int N        = 4;
  localparam int BIT      = 16 * N;
  localparam int LAT      = 2 + 153 * N;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int last_done_cyc = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] mon_exp;
  logic [7:0] exp_q[$];

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_byte_rx #(
    .CLK_FREQ (CLK_FREQ),
    .baud     (BAUD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .data      (data),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int bp,
                           input logic stop_v);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (bp) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    int f0;
    int t0;
    int lat;
    int gap;
    int bp;
    logic [7:0] b;

    fork
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          prev_data = data;
        end else begin
          checks++;
          assert (!(rx_done && frame_err) &&
                  (rx_done || data === prev_data)) else begin
            errors++;
            $error("FAIL strobe_hold got done=%b ferr=%b data=%h exp data=%h",
                   rx_done, frame_err, data, prev_data);
          end
          if (rx_done) begin
            mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            assert (data === mon_exp) else begin
              errors++;
              $error("FAIL rx_byte got %h exp %h", data, mon_exp);
            end
            done_cnt++;
            last_done_cyc = cyc;
          end
          if (frame_err) ferr_cnt++;
          prev_data = data;
        end
      end
    join_none

    repeat (5) @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_done", 32'(rx_done), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(WAIT_IDLE));
    reset_n = 1'b1;
    idle(4 * BIT);

    d0 = done_cnt;
    f0 = ferr_cnt;
    t0 = cyc;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, BIT, 1'b1);
    idle(BIT);
    wait_drain(4 * BIT);
    lat = last_done_cyc - t0;
    chk("t1_data", 32'(data), 32'hA5);
    chk("t1_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
    checks++;
    assert (lat >= LAT - 2 && lat <= LAT + 2) else begin
      errors++;
      $error("FAIL t1_latency got %0d exp %0d+/-2", lat, LAT);
    end

    d0 = done_cnt;
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(2 * BIT);
    chk("t2_glitch_done", 32'(done_cnt - d0), 32'd0);
    chk("t2_glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("t2_state", 32'(dut.state), 32'(IDLE));
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, BIT, 1'b1);
    idle(BIT);
    wait_drain(4 * BIT);
    chk("t2_data", 32'(data), 32'h3C);
    chk("t2_pulses", 32'(done_cnt - d0), 32'd1);

    d0 = done_cnt;
    f0 = ferr_cnt;
    send_byte(8'h3C, BIT, 1'b0);
    uart_rx = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    idle(2 * BIT);
    chk("t3_ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t3_data_held", 32'(data), 32'h3C);
    exp_q.push_back(8'h55);
    send_byte(8'h55, BIT, 1'b1);
    idle(BIT);
    wait_drain(4 * BIT);
    chk("t3_data", 32'(data), 32'h55);
    chk("t3_pulses", 32'(done_cnt - d0), 32'd1);

    d0 = done_cnt;
    f0 = ferr_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_byte(8'h00, 66, 1'b1);
    send_byte(8'hFF, 66, 1'b1);
    send_byte(8'h81, 66, 1'b1);
    idle(2 * BIT);
    wait_drain(4 * BIT);
    chk("t4_pulses", 32'(done_cnt - d0), 32'd3);
    chk("t4_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("t4_data", 32'(data), 32'h81);

    d0 = done_cnt;
    f0 = ferr_cnt;
    fork
      send_byte(8'h00, BIT, 1'b1);
      begin
        repeat (4 * BIT + 16) @(negedge clk);
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_rst_data", 32'(data), 32'h00);
        chk("t5_rst_done", 32'(rx_done), 32'd0);
        chk("t5_rst_ferr", 32'(frame_err), 32'd0);
        repeat (2 * BIT - 4) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    idle(BIT);
    chk("t5_lost_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_lost_ferr", 32'(ferr_cnt - f0), 32'd0);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, BIT, 1'b1);
    idle(BIT);
    wait_drain(4 * BIT);
    chk("t5_data", 32'(data), 32'hC3);
    chk("t5_pulses", 32'(done_cnt - d0), 32'd1);

    d0 = done_cnt;
    f0 = ferr_cnt;
    for (int i = 0; i < 40; i++) begin
      b   = 8'($urandom);
      bp  = int'($urandom_range(63, 65));
      gap = int'($urandom_range(0, 3)) * bp;
      exp_q.push_back(b);
      send_byte(b, bp, 1'b1);
      if (gap > 0) idle(gap);
    end
    idle(2 * BIT);
    wait_drain(4 * BIT);
    chk("t6_pulses", 32'(done_cnt - d0), 32'd40);
    chk("t6_ferr", 32'(ferr_cnt - f0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
